// File: rtl/nn_pkg.sv
// Shared types for the NN datapath: accumulator FSM states, default widths,
// and signed psum/acc/activation types.
package nn_pkg;

    localparam int PSUM_W = 32;
    localparam int ACC_W  = 40;
    localparam int ACT_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SCALE = 2'd2,
        OUT   = 2'd3
    } psum_state_e;

    typedef logic signed [PSUM_W-1:0] psum_t;
    typedef logic signed [ACC_W-1:0]  acc_t;
    typedef logic signed [ACT_W-1:0]  act_t;

endpackage

// File: rtl/round_sat.sv
// Combinational requantizer: rounding arithmetic right shift, optional ReLU,
// clip to the activation width. ReLU is enabled by defining PSUM_ACC_RELU_EN.
module round_sat #(
    parameter int ACC_WIDTH   = 40,
    parameter int OUT_WIDTH   = 8,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic [ACC_WIDTH-1:0]   acc,
    input  logic [SHIFT_WIDTH-1:0] shift,
    output logic [OUT_WIDTH-1:0]   data,
    output logic                   sat
);

    localparam int W = ACC_WIDTH + 1;
    localparam logic signed [W-1:0] MAXV = {{(W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [W-1:0] MINV = {{(W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    // One extra bit keeps acc + half-LSB from overflowing before the shift.
    function automatic logic signed [W-1:0] round_shift(
        input logic signed [ACC_WIDTH-1:0] a,
        input logic [SHIFT_WIDTH-1:0]      s
    );
        logic signed [W-1:0] ext;
        logic signed [W-1:0] one;
        logic signed [W-1:0] rnd;
        ext = W'(a);
        one = W'(1);
        rnd = (s != '0) ? (one <<< (s - 1'b1)) : '0;
        if (32'(s) >= ACC_WIDTH)
            return a[ACC_WIDTH-1] ? '1 : '0;
        return (ext + rnd) >>> s;
    endfunction

    function automatic logic signed [W-1:0] saturate(input logic signed [W-1:0] r);
        if (r > MAXV)
            return MAXV;
        if (r < MINV)
            return MINV;
        return r;
    endfunction

    logic signed [W-1:0] r;
    logic signed [W-1:0] rc;

    always_comb begin
        r = round_shift($signed(acc), shift);
`ifdef PSUM_ACC_RELU_EN
        if (r[W-1])
            r = '0;
`endif
        rc   = saturate(r);
        sat  = (rc != r);
        data = rc[OUT_WIDTH-1:0];
    end

endmodule

// File: rtl/psum_accumulator.sv
// Multi-beat dot-product accumulator with bias, rounding rescale and saturation.
// Optional ReLU in the requantizer when PSUM_ACC_RELU_EN is defined.
module psum_accumulator
    import nn_pkg::*;
#(
    parameter int IN_WIDTH    = PSUM_W,
    parameter int ACC_WIDTH   = ACC_W,
    parameter int OUT_WIDTH   = ACT_W,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [IN_WIDTH-1:0]    in_data,
    input  logic                   in_last,
    input  logic [ACC_WIDTH-1:0]   bias,
    input  logic [SHIFT_WIDTH-1:0] shift,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_WIDTH-1:0]   out_data,
    output logic                   out_sat
);

    psum_state_e state, state_nxt;

    logic signed [ACC_WIDTH-1:0] acc_p0, acc_nxt;
    logic signed [ACC_WIDTH-1:0] in_ext, bias_ext;
    logic [SHIFT_WIDTH-1:0]      shift_p0;
    logic [OUT_WIDTH-1:0]        out_data_p1, rs_data;
    logic                        out_sat_p1, rs_sat;
    logic                        beat;

    assign in_ext    = ACC_WIDTH'($signed(in_data));
    assign bias_ext  = $signed(bias);
    assign in_ready  = (state == IDLE) || (state == ACCUM);
    assign beat      = in_valid && in_ready;
    assign out_valid = (state == OUT);
    assign out_data  = out_data_p1;
    assign out_sat   = out_sat_p1;

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc_p0;
        case (state)
            IDLE: if (beat) begin
                acc_nxt   = bias_ext + in_ext;
                state_nxt = in_last ? SCALE : ACCUM;
            end
            ACCUM: if (beat) begin
                acc_nxt = acc_p0 + in_ext;
                if (in_last)
                    state_nxt = SCALE;
            end
            SCALE:   state_nxt = OUT;
            OUT:     if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p0: accumulation; stage p1: registered requantized result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            acc_p0      <= '0;
            shift_p0    <= '0;
            out_data_p1 <= '0;
            out_sat_p1  <= 1'b0;
        end else begin
            state  <= state_nxt;
            acc_p0 <= acc_nxt;
            if (state == IDLE && beat)
                shift_p0 <= shift;
            if (state == SCALE) begin
                out_data_p1 <= rs_data;
                out_sat_p1  <= rs_sat;
            end
        end
    end

    round_sat #(
        .ACC_WIDTH  (ACC_WIDTH),
        .OUT_WIDTH  (OUT_WIDTH),
        .SHIFT_WIDTH(SHIFT_WIDTH)
    ) u_round_sat (
        .acc  (acc_p0),
        .shift(shift_p0),
        .data (rs_data),
        .sat  (rs_sat)
    );

endmodule
